// File: rtl/stage_sequencer_if.sv
// Handshake bundle between stage_sequencer and decoder / ALU / TX / RX engines.
// master: decoder+engines side (drives instruction and engine status); slave: sequencer.
interface stage_sequencer_if #(
    parameter int NUM_STAGES      = 4,
    parameter int MAX_OUTSTANDING = 2
);
    localparam int SB = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int OB = $clog2(MAX_OUTSTANDING + 1);

    logic                  inst_valid;
    logic                  inst_done;
    logic [NUM_STAGES-1:0] stage_mask;
    logic [NUM_STAGES-1:0] stage_sends_cmd;
    logic [NUM_STAGES-1:0] stage_wants_reply;
    logic                  need_imm;
    logic                  imm_loaded;
    logic                  load_imm;
    logic                  use_cc;
    logic [3:0]            cc;
    logic [3:0]            flags;
    logic [SB-1:0]         stage;
    logic                  tx_command_valid;
    logic                  tx_command_started;
    logic                  tx_data_next;
    logic                  rx_data_valid;
    logic                  rx_done;
    logic                  alu_en;
    logic                  op_done;
    logic [OB-1:0]         outstanding;
    logic                  error;

    modport master (
        output inst_valid, stage_mask, stage_sends_cmd, stage_wants_reply,
        output need_imm, imm_loaded, use_cc, cc, flags,
        output tx_command_started, tx_data_next, rx_data_valid, rx_done,
        output op_done,
        input  inst_done, load_imm, stage, tx_command_valid, alu_en,
        input  outstanding, error
    );

    modport slave (
        input  inst_valid, stage_mask, stage_sends_cmd, stage_wants_reply,
        input  need_imm, imm_loaded, use_cc, cc, flags,
        input  tx_command_started, tx_data_next, rx_data_valid, rx_done,
        input  op_done,
        output inst_done, load_imm, stage, tx_command_valid, alu_en,
        output outstanding, error
    );
endinterface

// File: rtl/stage_sequencer.sv
// Instruction stage controller: steps one instruction through masked stages,
// handles imm16 fetch, cc skip, TX command issue, reply tracking and ALU gating.
// Ports: clk, reset (sync, active-high), bus (stage_sequencer_if.slave).
// Option: define SEQ_WATCHDOG_EN to enable the reply watchdog and sticky error.
module stage_sequencer #(
    parameter int NUM_STAGES      = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT         = 255
) (
    input logic             clk,
    input logic             reset,
    stage_sequencer_if.slave bus
);
    localparam int SB = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int OB = $clog2(MAX_OUTSTANDING + 1);

    if (NUM_STAGES < 2 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("stage_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        IMM,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [SB-1:0] stage_q;
    logic [OB-1:0] out_q;
    logic [OB-1:0] out_nxt;
    logic          cmd_started;
    logic          imm_avail;
    logic          inst_done_q;
    logic          load_imm_q;

    logic          cur_sends;
    logic          cur_wants;
    logic          cc_base;
    logic          cc_ok;
    logic          first_found;
    logic [SB-1:0] first_idx;
    logic          next_found;
    logic [SB-1:0] next_idx;
    logic          inc;
    logic          dec;
    logic          wd_hit;
    logic          in_run;

    assign in_run    = (state == RUN);
    assign cur_sends = bus.stage_sends_cmd[stage_q];
    assign cur_wants = bus.stage_wants_reply[stage_q];

    // flags = {c,v,s,z}; cc[3] inverts the base condition
    always_comb begin
        cc_base = 1'b1;
        unique case (bus.cc[2:0])
            3'd0:    cc_base = 1'b1;
            3'd1:    cc_base = bus.flags[0];
            3'd2:    cc_base = bus.flags[1];
            3'd3:    cc_base = bus.flags[3];
            3'd4:    cc_base = bus.flags[3] & ~bus.flags[0];
            3'd5:    cc_base = bus.flags[2];
            3'd6:    cc_base = bus.flags[2] & ~bus.flags[0];
            default: cc_base = 1'b1;
        endcase
        cc_ok = cc_base ^ bus.cc[3];
    end

    // Downward scan so the last hit is the lowest qualifying index
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (bus.stage_mask[i]) begin
                first_found = 1'b1;
                first_idx   = SB'(i);
            end
            if (bus.stage_mask[i] && (i > int'(stage_q))) begin
                next_found = 1'b1;
                next_idx   = SB'(i);
            end
        end
    end

    assign inc = in_run && bus.tx_command_started && cur_wants;
    assign dec = bus.rx_done;

    // Simultaneous issue and reply cancel; saturate at both ends
    always_comb begin
        out_nxt = out_q;
        if (inc && !dec && (out_q != OB'(MAX_OUTSTANDING)))
            out_nxt = out_q + OB'(1);
        else if (dec && !inc && (out_q != '0))
            out_nxt = out_q - OB'(1);
    end

    assign bus.tx_command_valid = in_run && cur_sends && !cmd_started
                                  && (out_q != OB'(MAX_OUTSTANDING));

    assign bus.alu_en = in_run
                        && (!cur_sends || (cmd_started && bus.tx_data_next))
                        && (!cur_wants || bus.rx_data_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            stage_q     <= '0;
            out_q       <= '0;
            cmd_started <= 1'b0;
            imm_avail   <= 1'b0;
            inst_done_q <= 1'b0;
            load_imm_q  <= 1'b0;
        end else begin
            inst_done_q <= 1'b0;
            out_q       <= out_nxt;
            unique case (state)
                IDLE: begin
                    if (bus.inst_valid)
                        state <= EVAL;
                end
                EVAL: begin
                    if (bus.use_cc && !cc_ok) begin
                        state       <= DONE;
                        inst_done_q <= 1'b1;
                    end else if (bus.need_imm && !imm_avail) begin
                        state      <= IMM;
                        load_imm_q <= 1'b1;
                    end else if (first_found) begin
                        state       <= RUN;
                        stage_q     <= first_idx;
                        cmd_started <= 1'b0;
                    end else begin
                        state       <= DONE;
                        inst_done_q <= 1'b1;
                    end
                end
                IMM: begin
                    if (bus.imm_loaded) begin
                        imm_avail  <= 1'b1;
                        load_imm_q <= 1'b0;
                        state      <= EVAL;
                    end
                end
                RUN: begin
                    if (bus.tx_command_started)
                        cmd_started <= 1'b1;
                    if (wd_hit) begin
                        state       <= DONE;
                        inst_done_q <= 1'b1;
                        out_q       <= '0;
                        cmd_started <= 1'b0;
                    end else if (bus.op_done) begin
                        cmd_started <= 1'b0;
                        if (next_found) begin
                            stage_q <= next_idx;
                        end else begin
                            state       <= DONE;
                            inst_done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    imm_avail <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_WATCHDOG_EN
    logic [7:0] wd;
    logic       err_q;

    assign wd_hit = in_run && (wd == 8'(TIMEOUT));

    // Counts only while waiting on a reply for an already started command
    always_ff @(posedge clk) begin
        if (reset)
            wd <= '0;
        else if (!in_run || bus.rx_data_valid || bus.op_done || wd_hit)
            wd <= '0;
        else if (cur_wants && cmd_started)
            wd <= wd + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (wd_hit)
            err_q <= 1'b1;
    end

    assign bus.error = err_q;
`else
    assign wd_hit    = 1'b0;
    assign bus.error = 1'b0;
`endif

    assign bus.stage       = stage_q;
    assign bus.inst_done   = inst_done_q;
    assign bus.load_imm    = load_imm_q;
    assign bus.outstanding = out_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer (scoreboard of stages and done times).
// Build with SEQ_WATCHDOG_EN to also exercise the watchdog.
module tb_stage_sequencer;
    localparam int NS = 4;
    localparam int MO = 2;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_out = 0;
    int   stage_q[$];
    int   done_q[$];
    int   fa, txc, ldc, pim;

    stage_sequencer_if #(.NUM_STAGES(NS), .MAX_OUTSTANDING(MO)) bus ();

    stage_sequencer #(
        .NUM_STAGES(NS),
        .MAX_OUTSTANDING(MO),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit cc_model(input logic [3:0] c, input logic [3:0] f);
        bit r;
        case (c[2:0])
            3'd0: r = 1'b1;
            3'd1: r = f[0];
            3'd2: r = f[1];
            3'd3: r = f[3];
            3'd4: r = f[3] & ~f[0];
            3'd5: r = f[2];
            3'd6: r = f[2] & ~f[0];
            default: r = 1'b1;
        endcase
        return c[3] ? !r : r;
    endfunction

    task automatic idle_inputs();
        bus.inst_valid = 0; bus.stage_mask = 0;
        bus.stage_sends_cmd = 0; bus.stage_wants_reply = 0;
        bus.need_imm = 0; bus.imm_loaded = 0; bus.use_cc = 0;
        bus.cc = 0; bus.flags = 0; bus.tx_command_started = 0;
        bus.tx_data_next = 1; bus.rx_data_valid = 1;
        bus.rx_done = 0; bus.op_done = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, bus.inst_done, 0);
        check({tag, "_ldimm"}, bus.load_imm, 0);
        check({tag, "_stage"}, bus.stage, 0);
        check({tag, "_txv"}, bus.tx_command_valid, 0);
        check({tag, "_alu"}, bus.alu_en, 0);
        check({tag, "_out"}, bus.outstanding, 0);
        check({tag, "_err"}, bus.error, 0);
    endtask

    task automatic run_inst(input logic [3:0] mask, input logic [3:0] snd,
                            input logic [3:0] wnt, input bit nimm,
                            input bit ucc, input logic [3:0] ccv,
                            input logic [3:0] flg, input int lat,
                            input bit rxv, output int first_alu,
                            output int tx_cnt, output int ld_cnt,
                            output int pre_imm);
        bit ok, in_op, in_stage, done, imm_done;
        int t0, alu_t, cur_st, wd_cyc;
        ok = !ucc || cc_model(ccv, flg);
        in_op = 0; in_stage = 0; done = 0; imm_done = !nimm;
        first_alu = -1; tx_cnt = 0; ld_cnt = 0; pre_imm = 0;
        alu_t = 0; cur_st = 0; wd_cyc = -1;
        if (ok)
            for (int i = 0; i < NS; i++)
                if (mask[i]) stage_q.push_back(i);
        @(negedge clk);
        bus.stage_mask = mask; bus.stage_sends_cmd = snd;
        bus.stage_wants_reply = wnt; bus.need_imm = nimm;
        bus.use_cc = ucc; bus.cc = ccv; bus.flags = flg;
        bus.tx_data_next = 1; bus.rx_data_valid = rxv;
        bus.inst_valid = 1;
        t0 = cyc;
        if (!ok || (mask == 0 && !nimm)) done_q.push_back(t0 + 2);
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            bus.op_done = 0; bus.imm_loaded = 0;
            bus.tx_command_started = 0;
            if (cyc == wd_cyc) exp_out = 0;
            check("outstanding", bus.outstanding, exp_out);
            if (bus.alu_en && !imm_done) pre_imm++;
            if (bus.load_imm) begin
                ld_cnt++;
                if (ld_cnt == 3) begin
                    bus.imm_loaded = 1; imm_done = 1;
                    if (ok && mask == 0) done_q.push_back(cyc + 2);
                end
            end
            if ((bus.tx_command_valid || bus.alu_en) && !in_stage) begin
                in_stage = 1;
                check("stage_q_nonempty", stage_q.size() > 0, 1);
                if (stage_q.size() > 0) begin
                    cur_st = stage_q.pop_front();
                    check("stage", bus.stage, cur_st);
                end
            end
            if (bus.tx_command_valid) begin
                tx_cnt++;
                bus.tx_command_started = 1;
                if (wnt[cur_st] && exp_out < MO) exp_out++;
`ifdef SEQ_WATCHDOG_EN
                if (wnt[cur_st] && !rxv) begin
                    wd_cyc = cyc + TO + 2;
                    done_q.push_back(wd_cyc);
                end
`endif
            end
            if (bus.alu_en && !in_op) begin
                in_op = 1; alu_t = cyc;
                if (first_alu < 0) first_alu = cyc - t0;
            end
            if (in_op && cyc == alu_t + lat) begin
                bus.op_done = 1; in_op = 0; in_stage = 0;
                if (stage_q.size() == 0) done_q.push_back(cyc + 1);
            end
            if (bus.inst_done) begin
                check("done_q_depth", done_q.size(), 1);
                if (done_q.size() > 0) check("done_cyc", cyc, done_q.pop_front());
                check("stages_left", stage_q.size(), 0);
                done = 1; bus.inst_valid = 0;
            end
        end
        check("done_seen", done, 1);
        @(negedge clk);
        bus.op_done = 0; bus.imm_loaded = 0; bus.tx_command_started = 0;
        check("done_pulse", bus.inst_done, 0);
        stage_q.delete(); done_q.delete();
    endtask

    initial begin
        logic [3:0] cc_tab [6];
        logic [3:0] fl_tab [6];
        cc_tab = '{4'd4, 4'd4, 4'd8, 4'd14, 4'd3, 4'd2};
        fl_tab = '{4'b1000, 4'b1001, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
        idle_inputs();
        reset = 1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 0;

        run_inst(4'b0101, 0, 0, 0, 0, 0, 0, 8, 1, fa, txc, ldc, pim);
        check("t1_first_alu", fa, 2);
        check("t1_tx", txc, 0);

        run_inst(4'b0001, 4'b0001, 0, 0, 1, 4'd1, 4'b0000, 3, 1,
                 fa, txc, ldc, pim);
        check("t2_skip_alu", fa, -1);
        check("t2_skip_tx", txc, 0);
        run_inst(4'b0001, 0, 0, 0, 1, 4'd9, 4'b0000, 3, 1, fa, txc, ldc, pim);
        check("t2_exec_alu", fa, 2);

        for (int k = 0; k < 6; k++) begin
            run_inst(4'b0010, 0, 0, 0, 1, cc_tab[k], fl_tab[k], 2, 1,
                     fa, txc, ldc, pim);
            check("cc_table", fa, cc_model(cc_tab[k], fl_tab[k]) ? 2 : -1);
        end

        run_inst(4'b1000, 0, 0, 1, 0, 0, 0, 2, 1, fa, txc, ldc, pim);
        check("t3_ld_cycles", ldc, 3);
        check("t3_pre_imm_alu", pim, 0);
        check("t3_first_alu", fa, 6);
        run_inst(4'b1000, 0, 0, 1, 0, 0, 0, 2, 1, fa, txc, ldc, pim);
        check("t3_imm_cleared", ldc, 3);

        run_inst(4'b0011, 4'b0010, 0, 0, 0, 0, 0, 3, 1, fa, txc, ldc, pim);
        check("cmd_tx_count", txc, 1);
        run_inst(4'b0000, 0, 0, 0, 0, 0, 0, 2, 1, fa, txc, ldc, pim);
        check("empty_mask_alu", fa, -1);

        run_inst(4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0, 2, 1,
                 fa, txc, ldc, pim);
        run_inst(4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0, 2, 1,
                 fa, txc, ldc, pim);
        check("t4_out_full", bus.outstanding, 2);
        bus.stage_mask = 4'b0001; bus.stage_sends_cmd = 4'b0001;
        bus.stage_wants_reply = 4'b0001; bus.rx_data_valid = 1;
        bus.tx_data_next = 0; bus.inst_valid = 1;
        repeat (6) begin
            @(negedge clk);
            check("t4_hold", bus.tx_command_valid, 0);
        end
        bus.rx_done = 1;
        @(negedge clk);
        bus.rx_done = 0;
        check("t4_out_dec", bus.outstanding, 1);
        check("t4_issue", bus.tx_command_valid, 1);
        bus.tx_command_started = 1;
        @(negedge clk);
        bus.tx_command_started = 0;
        check("t4_out_inc", bus.outstanding, 2);
        check("t4_gate_txnext", bus.alu_en, 0);
        bus.tx_data_next = 1;
        #1;
        check("t4_alu_on", bus.alu_en, 1);
        bus.op_done = 1;
        @(negedge clk);
        bus.op_done = 0;
        check("t4_done", bus.inst_done, 1);
        bus.inst_valid = 0;

        @(negedge clk);
        bus.rx_done = 1;
        @(negedge clk);
        bus.rx_done = 0;
        check("t5_dec", bus.outstanding, 1);
        bus.inst_valid = 1;
        for (int n = 0; n < 10 && !bus.tx_command_valid; n++) @(negedge clk);
        check("t5_txv", bus.tx_command_valid, 1);
        bus.tx_command_started = 1; bus.rx_done = 1;
        @(negedge clk);
        bus.tx_command_started = 0; bus.rx_done = 0;
        check("t5_same_cycle", bus.outstanding, 1);
        check("t5_alu", bus.alu_en, 1);
        reset = 1; bus.inst_valid = 0;
        @(negedge clk);
        check_all_zero("t5_reset");
        reset = 0; exp_out = 0;
        idle_inputs();

`ifdef SEQ_WATCHDOG_EN
        run_inst(4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0, 2, 0,
                 fa, txc, ldc, pim);
        check("t6_error", bus.error, 1);
        check("t6_no_alu", fa, -1);
        run_inst(4'b0001, 0, 0, 0, 0, 0, 0, 2, 1, fa, txc, ldc, pim);
        check("t6_error_sticky", bus.error, 1);
        reset = 1;
        @(negedge clk);
        check("t6_error_clr", bus.error, 0);
        reset = 0;
`else
        run_inst(4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0, 2, 1,
                 fa, txc, ldc, pim);
        check("error_tied", bus.error, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
